vending_machine_n: RTL and testbench

VENDING_MACHINE_N -- requirements
Module: vending_machine_n

---
 rtl/vending_machine_n_if.sv | 62 ++++++
 rtl/vending_machine_n.sv | 236 +++++++++++++++++++++++
 tb/tb_vending_machine_n.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_machine_n_if.sv
// vending_machine_n_if -- customer and status bundle for vending_machine_n.
//
// Strobe semantics: coin_valid, sel_valid and refund are single-cycle
// strobes sampled on every rising clock edge. There is no ready signal. The
// machine answers every strobe one cycle later, with dispense, sel_error or
// coin_reject, or by changing state.
//
// master: customer side. It drives coin_valid/coin, refund,
//         sel_valid/sel and stock.
// slave : machine side. It drives dispense/dispense_id, credit, state,
//         exact_change_only, the coin_reject/sel_error/change_short/
//         change_valid pulses, the per-transaction *_out change counters
//         and the *_cnt coin inventory.
interface vending_machine_n_if #(
  parameter int NUM_PRODUCTS = 6,
  parameter int CREDIT_W     = 8,
  parameter int CNT_W        = 5
);
  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;

  logic                    coin_valid;
  logic [2:0]              coin;
  logic                    refund;
  logic                    sel_valid;
  logic [SEL_W-1:0]        sel;
  logic [NUM_PRODUCTS-1:0] stock;

  logic                    dispense;
  logic [SEL_W-1:0]        dispense_id;
  logic [CREDIT_W-1:0]     credit;
  logic [1:0]              state;
  logic                    exact_change_only;
  logic                    coin_reject;
  logic                    sel_error;
  logic                    change_short;
  logic                    change_valid;
  logic [CNT_W-1:0]        nickel_out;
  logic [CNT_W-1:0]        dime_out;
  logic [CNT_W-1:0]        quarter_out;
  logic [CNT_W-1:0]        half_out;
  logic [CNT_W-1:0]        nickel_cnt;
  logic [CNT_W-1:0]        dime_cnt;
  logic [CNT_W-1:0]        quarter_cnt;
  logic [CNT_W-1:0]        half_cnt;
  logic [CNT_W-1:0]        dollar_cnt;

  modport master (
    output coin_valid, coin, refund, sel_valid, sel, stock,
    input  dispense, dispense_id, credit, state, exact_change_only,
           coin_reject, sel_error, change_short, change_valid,
           nickel_out, dime_out, quarter_out, half_out,
           nickel_cnt, dime_cnt, quarter_cnt, half_cnt, dollar_cnt
  );

  modport slave (
    input  coin_valid, coin, refund, sel_valid, sel, stock,
    output dispense, dispense_id, credit, state, exact_change_only,
           coin_reject, sel_error, change_short, change_valid,
           nickel_out, dime_out, quarter_out, half_out,
           nickel_cnt, dime_cnt, quarter_cnt, half_cnt, dollar_cnt
  );
endinterface

// File: rtl/vending_machine_n.sv
// vending_machine_n -- multi-product vending machine with coin inventory and
// greedy change return. Credit is counted in nickels ($0.05 units).
//
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous, active-low reset
//   bus  : vending_machine_n_if.slave. It carries the coin, selection and
//          refund strobes, the stock mask, and every status, pulse and
//          counter output. bus.state exposes the FSM state
//          (IDLE=0, COLLECT=1, CHANGE=2, DONE=3).
//
// Flow: IDLE -> (first coin) COLLECT -> (valid selection or refund) CHANGE
//       -> (credit paid out, or short) DONE -> IDLE.
module vending_machine_n #(
  parameter int NUM_PRODUCTS = 6,
  parameter int CREDIT_W     = 8,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {6{8'd25}},
  parameter int MAX_CREDIT   = 100,
  parameter int CNT_W        = 5,
  parameter int INIT_COUNT   = 20,
  parameter int EXACT_THRESH = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  vending_machine_n_if.slave   bus
);
  localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;

  localparam logic [CREDIT_W-1:0] V_N   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] V_D   = CREDIT_W'(2);
  localparam logic [CREDIT_W-1:0] V_Q   = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] V_H   = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] V_DOL = CREDIT_W'(20);

  localparam logic [CREDIT_W:0] MAX_C      = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [SEL_W:0]    NUM_PROD_W = (SEL_W+1)'(NUM_PRODUCTS);
  localparam logic [CNT_W:0]    EXACT_TH_W = (CNT_W+1)'(EXACT_THRESH);
  localparam logic [CNT_W-1:0]  INIT_W     = CNT_W'(INIT_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHANGE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    n_cnt, d_cnt, q_cnt, h_cnt, dol_cnt;
  logic [CNT_W-1:0]    n_out, d_out, q_out, h_out;
  logic                dispense_q, coin_reject_q, sel_error_q;
  logic                change_short_q, change_valid_q;
  logic [SEL_W-1:0]    dispense_id_q;

  // Decode results
  logic [CREDIT_W-1:0] coin_val;
  logic                coin_fits;
  logic                coin_accept;
  logic                coin_reject_d;
  logic                do_refund;
  logic                do_sel;
  logic                sel_in_range;
  logic [SEL_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic                sel_error_d;
  logic                exact_only;
  logic                credit_zero;
  logic                pay_h, pay_q, pay_d, pay_n, pay_any;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (coin_accept) state_d = COLLECT;
      COLLECT: if (do_refund || sel_ok) state_d = CHANGE;
      CHANGE:  if (credit_zero || !pay_any) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and control decode
  always_comb begin
    case (bus.coin)
      3'b001:  coin_val = V_N;
      3'b010:  coin_val = V_D;
      3'b011:  coin_val = V_Q;
      3'b100:  coin_val = V_H;
      3'b101:  coin_val = V_DOL;
      default: coin_val = '0;
    endcase
    coin_fits = ({1'b0, credit_q} + {1'b0, coin_val}) <= MAX_C;

    // refund beats a selection, and both of them beat a coin.
    do_refund = (state_q == COLLECT) && bus.refund;
    do_sel    = (state_q == COLLECT) && !bus.refund && bus.sel_valid;

    coin_accept = 1'b0;
    if (bus.coin_valid && (coin_val != '0) && coin_fits) begin
      if (state_q == IDLE)
        coin_accept = 1'b1;
      else if (state_q == COLLECT && !bus.refund && !bus.sel_valid)
        coin_accept = 1'b1;
    end
    coin_reject_d = bus.coin_valid && !coin_accept;

    // An out-of-range index is clamped so the price lookup stays in the
    // table. sel_in_range still rejects that selection.
    sel_in_range = {1'b0, bus.sel} < NUM_PROD_W;
    sel_idx      = sel_in_range ? bus.sel : '0;
    price        = PRICES[int'(sel_idx)*CREDIT_W +: CREDIT_W];
    exact_only   = {1'b0, n_cnt} < EXACT_TH_W;
    sel_ok       = do_sel && sel_in_range && bus.stock[sel_idx] &&
                   (credit_q >= price) && !(exact_only && credit_q != price);
    sel_error_d  = do_sel && !sel_ok;

    // Greedy change: the largest coin that fits the remaining credit and is
    // still in stock. Dollars are never paid back.
    credit_zero = (credit_q == '0);
    pay_h   = (credit_q >= V_H) && (h_cnt != '0);
    pay_q   = !pay_h && (credit_q >= V_Q) && (q_cnt != '0);
    pay_d   = !pay_h && !pay_q && (credit_q >= V_D) && (d_cnt != '0);
    pay_n   = !pay_h && !pay_q && !pay_d && (credit_q >= V_N) && (n_cnt != '0);
    pay_any = pay_h || pay_q || pay_d || pay_n;
  end

  // Datapath: credit, inventory, change counters and the registered pulses
  always_ff @(posedge clk) begin
    if (!rst) begin
      credit_q       <= '0;
      n_cnt          <= INIT_W;
      d_cnt          <= INIT_W;
      q_cnt          <= INIT_W;
      h_cnt          <= INIT_W;
      dol_cnt        <= INIT_W;
      n_out          <= '0;
      d_out          <= '0;
      q_out          <= '0;
      h_out          <= '0;
      dispense_q     <= 1'b0;
      dispense_id_q  <= '0;
      coin_reject_q  <= 1'b0;
      sel_error_q    <= 1'b0;
      change_short_q <= 1'b0;
      change_valid_q <= 1'b0;
    end else begin
      dispense_q     <= 1'b0;
      change_short_q <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= coin_reject_d;
      sel_error_q    <= sel_error_d;

      if (coin_accept) begin
        credit_q <= credit_q + coin_val;
        case (bus.coin)
          3'b001:  n_cnt   <= sat_inc(n_cnt);
          3'b010:  d_cnt   <= sat_inc(d_cnt);
          3'b011:  q_cnt   <= sat_inc(q_cnt);
          3'b100:  h_cnt   <= sat_inc(h_cnt);
          default: dol_cnt <= sat_inc(dol_cnt);
        endcase
        // The first coin of a transaction wipes the previous change report.
        if (state_q == IDLE) begin
          n_out <= '0;
          d_out <= '0;
          q_out <= '0;
          h_out <= '0;
        end
      end

      if (sel_ok) begin
        dispense_q    <= 1'b1;
        dispense_id_q <= bus.sel;
        credit_q      <= credit_q - price;
      end

      // change_valid is set on the way into DONE, so it is high during DONE.
      if (state_q == CHANGE) begin
        if (credit_zero) begin
          change_valid_q <= 1'b1;
        end else if (pay_h) begin
          h_cnt    <= h_cnt - 1'b1;
          h_out    <= h_out + 1'b1;
          credit_q <= credit_q - V_H;
        end else if (pay_q) begin
          q_cnt    <= q_cnt - 1'b1;
          q_out    <= q_out + 1'b1;
          credit_q <= credit_q - V_Q;
        end else if (pay_d) begin
          d_cnt    <= d_cnt - 1'b1;
          d_out    <= d_out + 1'b1;
          credit_q <= credit_q - V_D;
        end else if (pay_n) begin
          n_cnt    <= n_cnt - 1'b1;
          n_out    <= n_out + 1'b1;
          credit_q <= credit_q - V_N;
        end else begin
          change_short_q <= 1'b1;
          change_valid_q <= 1'b1;
          credit_q       <= '0;
        end
      end
    end
  end

  assign bus.dispense          = dispense_q;
  assign bus.dispense_id       = dispense_id_q;
  assign bus.credit            = credit_q;
  assign bus.state             = state_q;
  assign bus.exact_change_only = exact_only;
  assign bus.coin_reject       = coin_reject_q;
  assign bus.sel_error         = sel_error_q;
  assign bus.change_short      = change_short_q;
  assign bus.change_valid      = change_valid_q;
  assign bus.nickel_out        = n_out;
  assign bus.dime_out          = d_out;
  assign bus.quarter_out       = q_out;
  assign bus.half_out          = h_out;
  assign bus.nickel_cnt        = n_cnt;
  assign bus.dime_cnt          = d_cnt;
  assign bus.quarter_cnt       = q_cnt;
  assign bus.half_cnt          = h_cnt;
  assign bus.dollar_cnt        = dol_cnt;
endmodule

// File: tb/tb_vending_machine_n.sv
// tb_vending_machine_n -- directed bench for vending_machine_n.
// It runs three instances:
//   dut    : default parameters (INIT_COUNT=20)
//   dut_ec : INIT_COUNT=10, so the machine starts in exact-change mode
//   dut_z  : INIT_COUNT=0, an empty coin inventory for the short-change case
// One shared set of driver variables feeds whichever instance "which" names.
// The strobes to the other two instances are held low.
module tb_vending_machine_n;
  localparam logic [2:0] C_N = 3'b001, C_D = 3'b010, C_Q = 3'b011,
                         C_H = 3'b100, C_DOL = 3'b101, C_BAD = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   which = 0;

  logic       drv_coin_valid = 1'b0;
  logic [2:0] drv_coin       = 3'b000;
  logic       drv_refund     = 1'b0;
  logic       drv_sel_valid  = 1'b0;
  logic [2:0] drv_sel        = 3'b000;
  logic [5:0] drv_stock      = 6'b111111;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  vending_machine_n_if #(.NUM_PRODUCTS(6), .CREDIT_W(8), .CNT_W(5)) bus ();
  vending_machine_n_if #(.NUM_PRODUCTS(6), .CREDIT_W(8), .CNT_W(5)) bus_ec ();
  vending_machine_n_if #(.NUM_PRODUCTS(6), .CREDIT_W(8), .CNT_W(5)) bus_z ();

  assign bus.coin_valid    = drv_coin_valid && (which == 0);
  assign bus.coin          = drv_coin;
  assign bus.refund        = drv_refund && (which == 0);
  assign bus.sel_valid     = drv_sel_valid && (which == 0);
  assign bus.sel           = drv_sel;
  assign bus.stock         = drv_stock;
  assign bus_ec.coin_valid = drv_coin_valid && (which == 1);
  assign bus_ec.coin       = drv_coin;
  assign bus_ec.refund     = drv_refund && (which == 1);
  assign bus_ec.sel_valid  = drv_sel_valid && (which == 1);
  assign bus_ec.sel        = drv_sel;
  assign bus_ec.stock      = drv_stock;
  assign bus_z.coin_valid  = drv_coin_valid && (which == 2);
  assign bus_z.coin        = drv_coin;
  assign bus_z.refund      = drv_refund && (which == 2);
  assign bus_z.sel_valid   = drv_sel_valid && (which == 2);
  assign bus_z.sel         = drv_sel;
  assign bus_z.stock       = drv_stock;

  vending_machine_n dut (.clk(clk), .rst(rst), .bus(bus));
  vending_machine_n #(.INIT_COUNT(10)) dut_ec (.clk(clk), .rst(rst), .bus(bus_ec));
  vending_machine_n #(.INIT_COUNT(0))  dut_z  (.clk(clk), .rst(rst), .bus(bus_z));

  // Clock
  always #5 clk = ~clk;

  // Checker
  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Drivers. Everything happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [2:0] c);
    drv_coin_valid = 1'b1;
    drv_coin       = c;
    step();
    drv_coin_valid = 1'b0;
    drv_coin       = 3'b000;
  endtask

  task automatic choose(input logic [2:0] s);
    drv_sel_valid = 1'b1;
    drv_sel       = s;
    step();
    drv_sel_valid = 1'b0;
  endtask

  task automatic press_refund();
    drv_refund = 1'b1;
    step();
    drv_refund = 1'b0;
  endtask

  function automatic logic cur_change_valid();
    case (which)
      1:       return bus_ec.change_valid;
      2:       return bus_z.change_valid;
      default: return bus.change_valid;
    endcase
  endfunction

  // Steps until change_valid, with a budget of 20 cycles.
  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (!cur_change_valid() && cycles < 20) begin
      step();
      cycles++;
    end
    check_eq(tag, cur_change_valid(), 1);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    step();
    step();
    check_eq("rst_state", bus.state, 0);
    check_eq("rst_credit", bus.credit, 0);
    check_eq("rst_nickel_cnt", bus.nickel_cnt, 20);
    check_eq("rst_dollar_cnt", bus.dollar_cnt, 20);
    check_eq("rst_dispense", bus.dispense, 0);
    check_eq("rst_exact", bus.exact_change_only, 0);
    check_eq("rst_ec_exact", bus_ec.exact_change_only, 1);
    check_eq("rst_ec_nickel_cnt", bus_ec.nickel_cnt, 10);
    check_eq("rst_z_half_cnt", bus_z.half_cnt, 0);
    rst = 1'b1;
    step();

    // H + $1 = 30, select 1 (price 25) -> one quarter of change
    insert(C_H);
    check_eq("a_state_collect", bus.state, 1);
    check_eq("a_credit_h", bus.credit, 10);
    insert(C_DOL);
    check_eq("a_credit_30", bus.credit, 30);
    choose(3'd1);
    check_eq("a_dispense", bus.dispense, 1);
    check_eq("a_dispense_id", bus.dispense_id, 1);
    check_eq("a_credit_after_sel", bus.credit, 5);
    check_eq("a_state_change", bus.state, 2);
    step();
    check_eq("a_dispense_one_cycle", bus.dispense, 0);
    check_eq("a_quarter_out", bus.quarter_out, 1);
    wait_done("a_change_valid", cyc);
    check_eq("a_done_cycles", cyc, 1);
    check_eq("a_state_done", bus.state, 3);
    check_eq("a_credit_0", bus.credit, 0);
    check_eq("a_quarter_cnt", bus.quarter_cnt, 19);
    check_eq("a_half_cnt", bus.half_cnt, 21);
    check_eq("a_dollar_cnt", bus.dollar_cnt, 21);
    check_eq("a_short", bus.change_short, 0);
    step();
    check_eq("a_idle", bus.state, 0);
    check_eq("a_cv_pulse", bus.change_valid, 0);
    check_eq("a_out_hold", bus.quarter_out, 1);

    // $1 $1 Q D D N = 50, select 2 -> H, H, Q over three paying cycles
    insert(C_DOL);
    check_eq("b_out_cleared", bus.quarter_out, 0);
    insert(C_DOL);
    insert(C_Q);
    insert(C_D);
    insert(C_D);
    insert(C_N);
    check_eq("b_credit_50", bus.credit, 50);
    choose(3'd2);
    check_eq("b_dispense_id", bus.dispense_id, 2);
    check_eq("b_credit_25", bus.credit, 25);
    wait_done("b_change_valid", cyc);
    check_eq("b_done_cycles", cyc, 4);
    check_eq("b_half_out", bus.half_out, 2);
    check_eq("b_quarter_out", bus.quarter_out, 1);
    check_eq("b_dime_out", bus.dime_out, 0);
    check_eq("b_half_cnt", bus.half_cnt, 19);
    check_eq("b_dollar_cnt", bus.dollar_cnt, 23);
    step();

    // Out-of-stock and out-of-range selections, then a good one
    drv_stock = 6'b111110;
    insert(C_H);
    insert(C_DOL);
    choose(3'd6);
    check_eq("c_range_err", bus.sel_error, 1);
    choose(3'd0);
    check_eq("c_stock_err", bus.sel_error, 1);
    check_eq("c_stock_credit", bus.credit, 30);
    check_eq("c_stock_state", bus.state, 1);
    check_eq("c_no_dispense", bus.dispense, 0);
    choose(3'd3);
    check_eq("c_err_cleared", bus.sel_error, 0);
    check_eq("c_dispense", bus.dispense, 1);
    check_eq("c_dispense_id", bus.dispense_id, 3);
    wait_done("c_change_valid", cyc);
    check_eq("c_quarter_out", bus.quarter_out, 1);
    check_eq("c_half_out", bus.half_out, 0);
    check_eq("c_quarter_cnt", bus.quarter_cnt, 18);
    step();
    drv_stock = 6'b111111;

    // D D D N = 7, rejects in COLLECT and CHANGE, refund -> Q + D
    insert(C_D);
    insert(C_D);
    insert(C_D);
    insert(C_N);
    check_eq("d_credit_7", bus.credit, 7);
    insert(C_BAD);
    check_eq("d_bad_code_reject", bus.coin_reject, 1);
    check_eq("d_bad_code_credit", bus.credit, 7);
    choose(3'd1);
    check_eq("d_low_credit_err", bus.sel_error, 1);
    check_eq("d_reject_pulse", bus.coin_reject, 0);
    drv_refund     = 1'b1;
    drv_coin_valid = 1'b1;
    drv_coin       = C_N;
    step();
    drv_refund     = 1'b0;
    check_eq("d_refund_state", bus.state, 2);
    check_eq("d_refund_credit", bus.credit, 7);
    check_eq("d_refund_coin_reject", bus.coin_reject, 1);
    step();
    drv_coin_valid = 1'b0;
    drv_coin       = 3'b000;
    check_eq("d_change_coin_reject", bus.coin_reject, 1);
    check_eq("d_credit_2", bus.credit, 2);
    wait_done("d_change_valid", cyc);
    check_eq("d_quarter_out", bus.quarter_out, 1);
    check_eq("d_dime_out", bus.dime_out, 1);
    check_eq("d_nickel_out", bus.nickel_out, 0);
    check_eq("d_nickel_cnt", bus.nickel_cnt, 22);
    check_eq("d_dime_cnt", bus.dime_cnt, 24);
    step();

    // Exact-change instance: 30 != 25 is refused, refund gives H H H
    which = 1;
    insert(C_H);
    insert(C_DOL);
    choose(3'd0);
    check_eq("e_exact_err", bus_ec.sel_error, 1);
    check_eq("e_exact_credit", bus_ec.credit, 30);
    press_refund();
    check_eq("e_refund_state", bus_ec.state, 2);
    wait_done("e_refund_cv", cyc);
    check_eq("e_half_out", bus_ec.half_out, 3);
    check_eq("e_quarter_out", bus_ec.quarter_out, 0);
    check_eq("e_half_cnt", bus_ec.half_cnt, 8);
    step();
    insert(C_DOL);
    insert(C_Q);
    check_eq("e_credit_25", bus_ec.credit, 25);
    choose(3'd0);
    check_eq("e_dispense", bus_ec.dispense, 1);
    check_eq("e_credit_0", bus_ec.credit, 0);
    wait_done("e_exact_cv", cyc);
    check_eq("e_exact_cycles", cyc, 1);
    check_eq("e_all_out_zero",
             {bus_ec.half_out, bus_ec.quarter_out, bus_ec.dime_out, bus_ec.nickel_out}, 0);
    check_eq("e_dollar_cnt", bus_ec.dollar_cnt, 12);
    step();

    // Empty-inventory instance: refund of 30 pays one H, then runs short
    which = 2;
    insert(C_H);
    insert(C_DOL);
    press_refund();
    wait_done("g_cv", cyc);
    check_eq("g_cycles", cyc, 2);
    check_eq("g_short", bus_z.change_short, 1);
    check_eq("g_credit_0", bus_z.credit, 0);
    check_eq("g_half_out", bus_z.half_out, 1);
    step();
    check_eq("g_short_pulse", bus_z.change_short, 0);

    // Reset in the second CHANGE cycle
    which = 0;
    insert(C_DOL);
    insert(C_DOL);
    choose(3'd1);
    check_eq("f_credit_15", bus.credit, 15);
    step();
    check_eq("f_half_out_pre", bus.half_out, 1);
    check_eq("f_credit_5", bus.credit, 5);
    rst = 1'b0;
    step();
    check_eq("f_rst_state", bus.state, 0);
    check_eq("f_rst_credit", bus.credit, 0);
    check_eq("f_rst_half_out", bus.half_out, 0);
    check_eq("f_rst_half_cnt", bus.half_cnt, 20);
    check_eq("f_rst_quarter_cnt", bus.quarter_cnt, 20);
    check_eq("f_rst_dollar_cnt", bus.dollar_cnt, 20);
    check_eq("f_rst_dime_cnt", bus.dime_cnt, 20);
    check_eq("f_rst_dispense_id", bus.dispense_id, 0);
    check_eq("f_rst_cv", bus.change_valid, 0);
    rst = 1'b1;
    step();
    check_eq("f_post_quarter_out", bus.quarter_out, 0);
    check_eq("f_post_state", bus.state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
